hazard_stall_unit: RTL and testbench

- Producer-side companion to the EX/MEM and MEM/WB forwarding logic in the 5-stage MIPS pipeline.
- Detects hazards that forwarding cannot cover:
  - load-use
  - branch-in-ID operand dependences
  - multiply/divide HI/LO busy
- Drives PC/IF-ID write enables and the ID/EX bubble.
- Keeps its own shadow copy of the EX and MEM stage destinations so it is self-contained, plus a mult/div latency counter and a stall statistics counter.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/hazard_stall_unit_if.sv | 36 +++
 rtl/md_busy_counter.sv | 37 +++
 rtl/hazard_stall_unit.sv | 95 +++++++++
 tb/tb_hazard_stall_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/stall logic: stall cause codes,
// shadow-stage destination record and the register-match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_LU   = 2'b01,
        CAUSE_BR   = 2'b10,
        CAUSE_MD   = 2'b11
    } stall_cause_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } shadow_t;

    // $0 is hardwired, so a producer targeting it never creates a dependence.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
        return uses && (rd == src) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage decode fields in, pipeline control and stall status out.
// master = decode/pipeline side, slave = hazard unit.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_branch;
    logic             id_md_start;
    logic             id_md_read;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             md_busy;
    logic [1:0]       stall_cause;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, id_branch, id_md_start, id_md_read,
        input  pc_write, if_id_write, id_ex_bubble, md_busy, stall_cause, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, id_branch, id_md_start, id_md_read,
        output pc_write, if_id_write, id_ex_bubble, md_busy, stall_cause, stall_count
    );
endinterface

// File: rtl/md_busy_counter.sv
// Mult/div HI/LO latency tracker: loads on accepted issue, counts down to 0.
// busy_o is registered state; no backpressure of its own.
module md_busy_counter #(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic busy_o
);
    // The issue cycle itself is the first of MD_LAT, so the count seen from
    // the next cycle on is MD_LAT-1; HI/LO is readable once it reaches 0.
    localparam logic [3:0] LOAD_VAL = 4'(MD_LAT - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall detection for hazards forwarding cannot cover (load-use, branch-in-ID, HI/LO busy).
// Combinational stall from shadow state; stalls freeze PC/IF-ID and bubble ID/EX.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_unit_if.slave   hs
);

    shadow_t          ex_q, ex_d, mem_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy;
    logic             m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
    logic             lu, br, md, stall;
    logic [1:0]       cause;
    logic             mem_unused;

    assign mem_unused = mem_q.regwrite;

    md_busy_counter #(.MD_LAT(MD_LAT)) u_md (
        .clk    (clk),
        .reset  (reset),
        .load_i (hs.id_valid && hs.id_md_start && !stall),
        .busy_o (md_busy)
    );

    always_comb begin
        m_ex_rs  = reg_match(hs.id_uses_rs, hs.id_rs, ex_q.rd);
        m_ex_rt  = reg_match(hs.id_uses_rt, hs.id_rt, ex_q.rd);
        m_mem_rs = reg_match(hs.id_uses_rs, hs.id_rs, mem_q.rd);
        m_mem_rt = reg_match(hs.id_uses_rt, hs.id_rt, mem_q.rd);

        lu = hs.id_valid && ex_q.memread && (m_ex_rs || m_ex_rt);
        // ALU result is only in EX; a load in MEM has no path back to ID.
        br = hs.id_valid && hs.id_branch &&
             ((ex_q.regwrite && (m_ex_rs || m_ex_rt)) ||
              (mem_q.memread && (m_mem_rs || m_mem_rt)));
        md = hs.id_valid && md_busy && (hs.id_md_read || hs.id_md_start);
        stall = lu || br || md;

        if (lu) begin
            cause = CAUSE_LU;
        end else if (br) begin
            cause = CAUSE_BR;
        end else if (md) begin
            cause = CAUSE_MD;
        end else begin
            cause = CAUSE_NONE;
        end

        ex_d = '0;
        if (hs.id_valid && !stall) begin
            ex_d = '{rd: hs.id_rd, regwrite: hs.id_regwrite, memread: hs.id_memread};
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (reset) begin
            hs.pc_write     = 1'b0;
            hs.if_id_write  = 1'b0;
            hs.id_ex_bubble = 1'b1;
            hs.stall_cause  = CAUSE_NONE;
        end else begin
            hs.pc_write     = !stall;
            hs.if_id_write  = !stall;
            hs.id_ex_bubble = stall;
            hs.stall_cause  = cause;
        end
    end

    assign hs.md_busy     = md_busy;
    assign hs.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table plus randomized run of hazard_stall_unit against an
// instruction-history reference model.
module tb_hazard_stall_unit;
    localparam int MD_LAT   = 4;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) hif();

    hazard_stall_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hif.slave)
    );

    typedef struct {
        bit       rst, v;
        bit [4:0] rs, rt;
        bit       urs, urt;
        bit [4:0] rd;
        bit       rw, mr, br, mds, mdr;
    } stim_t;

    typedef struct {
        stim_t    s;
        bit       pc, ifw, bub;
        bit [1:0] cause;
        bit       busy;
        int       cnt;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: what was issued 1 and 2 cycles ago, when HI/LO becomes readable.
    bit [4:0] h_rd [2];
    bit       h_rw [2];
    bit       h_mr [2];
    int       cyc = 0;
    int       md_ready = 0;
    int       m_cnt = 0;

    function automatic stim_t mk(bit rst, bit v, int rs, int rt, bit urs, bit urt,
                                 int rd, bit rw, bit mr, bit br, bit mds, bit mdr);
        stim_t s;
        s.rst = rst; s.v = v; s.rs = 5'(rs); s.rt = 5'(rt); s.urs = urs; s.urt = urt;
        s.rd = 5'(rd); s.rw = rw; s.mr = mr; s.br = br; s.mds = mds; s.mdr = mdr;
        return s;
    endfunction

    function automatic stim_t nop();              return mk(0,0,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic stim_t alu(int d, int a, int b); return mk(0,1,a,b,1,1,d,1,0,0,0,0); endfunction
    function automatic stim_t lw(int d, int a);   return mk(0,1,a,d,1,0,d,1,1,0,0,0); endfunction
    function automatic stim_t beq(int a, int b);  return mk(0,1,a,b,1,1,0,0,0,1,0,0); endfunction
    function automatic stim_t mult(int a, int b); return mk(0,1,a,b,1,1,0,0,0,0,1,0); endfunction
    function automatic stim_t mflo(int d);        return mk(0,1,0,0,0,0,d,1,0,0,0,1); endfunction

    function automatic stim_t with_rst(stim_t s);
        stim_t r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic vec_t ev(stim_t s, bit pc, int cause, bit busy, int cnt);
        vec_t e;
        e.s = s; e.pc = pc; e.ifw = pc; e.bub = !pc;
        e.cause = 2'(cause); e.busy = busy; e.cnt = cnt;
        return e;
    endfunction

    function automatic bit dep(bit u, bit [4:0] src, bit [4:0] rd);
        return u && (src == rd) && (rd != 5'd0);
    endfunction

    function automatic void hazards(stim_t s, output bit lu, output bit br, output bit md);
        bit d0 = dep(s.urs, s.rs, h_rd[0]) || dep(s.urt, s.rt, h_rd[0]);
        bit d1 = dep(s.urs, s.rs, h_rd[1]) || dep(s.urt, s.rt, h_rd[1]);
        lu = s.v && h_mr[0] && d0;
        br = s.v && s.br && ((h_rw[0] && d0) || (h_mr[1] && d1));
        md = s.v && (cyc < md_ready) && (s.mdr || s.mds);
    endfunction

    function automatic vec_t model_expect(stim_t s);
        vec_t e;
        bit lu, br, md, st;
        hazards(s, lu, br, md);
        st = lu || br || md;
        e.s = s;
        e.busy = (cyc < md_ready);
        e.cnt = m_cnt;
        if (s.rst) begin
            e.pc = 0; e.ifw = 0; e.bub = 1; e.cause = 2'd0;
        end else begin
            e.pc = !st; e.ifw = !st; e.bub = st;
            e.cause = lu ? 2'd1 : br ? 2'd2 : md ? 2'd3 : 2'd0;
        end
        return e;
    endfunction

    task automatic model_commit(input stim_t s);
        bit lu, br, md, st;
        hazards(s, lu, br, md);
        st = lu || br || md;
        if (s.rst) begin
            h_rd = '{default: 0}; h_rw = '{default: 0}; h_mr = '{default: 0};
            md_ready = 0;
            m_cnt = 0;
        end else begin
            h_rd[1] = h_rd[0]; h_rw[1] = h_rw[0]; h_mr[1] = h_mr[0];
            if (s.v && !st) begin
                h_rd[0] = s.rd; h_rw[0] = s.rw; h_mr[0] = s.mr;
            end else begin
                h_rd[0] = 0; h_rw[0] = 0; h_mr[0] = 0;
            end
            if (s.v && s.mds && !st) md_ready = cyc + MD_LAT;
            if (st && m_cnt < CNT_MAX) m_cnt++;
        end
        cyc++;
    endtask

    task automatic apply(input stim_t s);
        reset           = s.rst;
        hif.id_valid    = s.v;
        hif.id_rs       = s.rs;
        hif.id_rt       = s.rt;
        hif.id_uses_rs  = s.urs;
        hif.id_uses_rt  = s.urt;
        hif.id_rd       = s.rd;
        hif.id_regwrite = s.rw;
        hif.id_memread  = s.mr;
        hif.id_branch   = s.br;
        hif.id_md_start = s.mds;
        hif.id_md_read  = s.mdr;
    endtask

    // mode 0: no check, 1: check against supplied vector, 2: check against model
    task automatic run_cycle(input string nm, input int idx, input int mode, input vec_t tv);
        vec_t e;
        @(posedge clk);
        #1 apply(tv.s);
        @(negedge clk);
        e = (mode == 1) ? tv : model_expect(tv.s);
        if (mode != 0) begin
            n_vec++;
            if (hif.pc_write !== e.pc || hif.if_id_write !== e.ifw ||
                hif.id_ex_bubble !== e.bub || hif.stall_cause !== e.cause ||
                hif.md_busy !== e.busy || hif.stall_count !== CNT_W'(e.cnt)) begin
                n_bad++;
                $display("FAIL %s #%0d: got pc=%b ifw=%b bub=%b cause=%b busy=%b cnt=%0d, want pc=%b ifw=%b bub=%b cause=%b busy=%b cnt=%0d",
                         nm, idx, hif.pc_write, hif.if_id_write, hif.id_ex_bubble,
                         hif.stall_cause, hif.md_busy, hif.stall_count,
                         e.pc, e.ifw, e.bub, e.cause, e.busy, e.cnt);
            end
        end
        model_commit(tv.s);
    endtask

    vec_t tbl[$];

    initial begin
        stim_t rs1 = with_rst(nop());
        tbl.push_back(ev(rs1,            0, 0, 0, 0));   // reset state
        tbl.push_back(ev(lw(8, 1),       1, 0, 0, 0));   // load-use
        tbl.push_back(ev(alu(9, 8, 10),  0, 1, 0, 0));
        tbl.push_back(ev(alu(9, 8, 10),  1, 0, 0, 1));
        tbl.push_back(ev(nop(),          1, 0, 0, 1));
        tbl.push_back(ev(alu(5, 1, 2),   1, 0, 0, 1));   // branch after ALU
        tbl.push_back(ev(beq(5, 6),      0, 2, 0, 1));
        tbl.push_back(ev(beq(5, 6),      1, 0, 0, 2));
        tbl.push_back(ev(nop(),          1, 0, 0, 2));
        tbl.push_back(ev(lw(5, 1),       1, 0, 0, 2));   // branch after load
        tbl.push_back(ev(beq(5, 0),      0, 1, 0, 2));
        tbl.push_back(ev(beq(5, 0),      0, 2, 0, 3));
        tbl.push_back(ev(beq(5, 0),      1, 0, 0, 4));
        tbl.push_back(ev(lw(0, 1),       1, 0, 0, 4));   // $0 and non-use
        tbl.push_back(ev(alu(9, 0, 0),   1, 0, 0, 4));
        tbl.push_back(ev(lw(7, 1),       1, 0, 0, 4));
        tbl.push_back(ev(mk(0,1,7,7,0,0,3,1,0,0,0,0), 1, 0, 0, 4));
        tbl.push_back(ev(mult(2, 3),     1, 0, 0, 4));   // mult/div latency
        tbl.push_back(ev(mflo(4),        0, 3, 1, 4));
        tbl.push_back(ev(mflo(4),        0, 3, 1, 5));
        tbl.push_back(ev(mflo(4),        0, 3, 1, 6));
        tbl.push_back(ev(mflo(4),        1, 0, 0, 7));
        tbl.push_back(ev(lw(5, 1),       1, 0, 0, 7));   // reset mid-branch-stall
        tbl.push_back(ev(beq(5, 0),      0, 1, 0, 7));
        tbl.push_back(ev(with_rst(beq(5, 0)), 0, 0, 0, 8));
        tbl.push_back(ev(beq(5, 0),      1, 0, 0, 0));
        tbl.push_back(ev(mult(2, 3),     1, 0, 0, 0));   // reset mid-mult
        tbl.push_back(ev(mflo(4),        0, 3, 1, 0));
        tbl.push_back(ev(with_rst(mflo(4)), 0, 0, 1, 1));
        tbl.push_back(ev(mflo(4),        1, 0, 0, 0));
        tbl.push_back(ev(nop(),          1, 0, 0, 0));

        apply(rs1);
        for (int i = 0; i < 2; i++) run_cycle("pre", i, 0, ev(rs1, 0, 0, 0, 0));

        foreach (tbl[i]) run_cycle("table", i, 1, tbl[i]);

        // Saturation: back-to-back mult + mflo stalls push the counter past all-ones.
        run_cycle("sat", 0, 2, ev(rs1, 0, 0, 0, 0));
        for (int i = 0; i < 25; i++) begin
            run_cycle("sat", i, 2, ev(mult(1, 2), 0, 0, 0, 0));
            for (int j = 0; j < MD_LAT; j++) run_cycle("sat", i, 2, ev(mflo(3), 0, 0, 0, 0));
        end

        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            int a = $urandom_range(0, 3);
            int b = $urandom_range(0, 3);
            int d = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: s = alu(d, a, b);
                1: s = lw(d, a);
                2: s = beq(a, b);
                3: s = mult(a, b);
                4: s = mflo(d);
                default: s = mk(0, 1, a, b, $urandom_range(0,1) != 0, $urandom_range(0,1) != 0,
                                d, $urandom_range(0,1) != 0, $urandom_range(0,1) != 0,
                                $urandom_range(0,1) != 0, $urandom_range(0,1) != 0,
                                $urandom_range(0,1) != 0);
            endcase
            if ($urandom_range(0, 7) == 0) s.v = 1'b0;
            if ($urandom_range(0, 299) == 0) s.rst = 1'b1;
            run_cycle("random", i, 2, ev(s, 0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
